// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: funct codes, ALU_control values,
// FSM states and the funct decoder.
package alu_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, ALU, SHIFT, RESP} state_e;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_mode_e;
  typedef enum logic [1:0] {OP_ALU, OP_SHIFT, OP_ERR} op_class_e;

  typedef struct packed {
    op_class_e   cls;
    logic [3:0]  ctrl;
    shift_mode_e mode;
    logic        ovf_en;  // only signed add/sub report overflow
  } decode_t;

  function automatic decode_t decode_funct(input logic [5:0] funct);
    decode_t d;
    d.cls    = OP_ERR;
    d.ctrl   = ALU_AND;
    d.mode   = SH_SLL;
    d.ovf_en = 1'b0;
    case (funct)
      FUNCT_ADD:  begin d.cls = OP_ALU; d.ctrl = ALU_ADD; d.ovf_en = 1'b1; end
      FUNCT_ADDU: begin d.cls = OP_ALU; d.ctrl = ALU_ADD; end
      FUNCT_SUB:  begin d.cls = OP_ALU; d.ctrl = ALU_SUB; d.ovf_en = 1'b1; end
      FUNCT_SUBU: begin d.cls = OP_ALU; d.ctrl = ALU_SUB; end
      FUNCT_AND:  begin d.cls = OP_ALU; d.ctrl = ALU_AND; end
      FUNCT_OR:   begin d.cls = OP_ALU; d.ctrl = ALU_OR;  end
      FUNCT_NOR:  begin d.cls = OP_ALU; d.ctrl = ALU_NOR; end
      FUNCT_SLT:  begin d.cls = OP_ALU; d.ctrl = ALU_SLT; end
      FUNCT_SLL:  begin d.cls = OP_SHIFT; d.mode = SH_SLL; end
      FUNCT_SRL:  begin d.cls = OP_SHIFT; d.mode = SH_SRL; end
      FUNCT_SRA:  begin d.cls = OP_SHIFT; d.mode = SH_SRA; end
      default:    d.cls = OP_ERR;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU driven by the 4-bit ALU_control encoding.
// Outputs are forced to zero while the block is held in reset.
module alu
  import alu_pkg::*;
(
  input  logic        rst_n,
  input  logic [3:0]  alu_control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        cout,
  output logic        overflow
);

  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    result   = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    if (rst_n) begin
      case (alu_control)
        ALU_AND: result = a & b;
        ALU_OR:  result = a | b;
        ALU_NOR: result = ~(a | b);
        ALU_ADD: begin
          result   = sum[31:0];
          cout     = sum[32];
          overflow = (a[31] == b[31]) && (sum[31] != a[31]);
        end
        ALU_SUB: begin
          result   = diff[31:0];
          cout     = diff[32];
          overflow = (a[31] != b[31]) && (diff[31] != a[31]);
        end
        ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
        default: result = '0;
      endcase
    end
  end

  assign zero = (result == '0);

endmodule

// File: rtl/shift_step.sv
// One step of the iterative shifter: shifts by 0..SHIFT_STEP bits in sll/srl/sra mode.
module shift_step
  import alu_pkg::*;
#(
  parameter int SHIFT_STEP = 1,
  localparam int AMT_W = $clog2(SHIFT_STEP + 1)
) (
  input  logic [31:0]      value,
  input  shift_mode_e      mode,
  input  logic [AMT_W-1:0] amount,
  output logic [31:0]      result
);

  always_comb begin
    result = value;
    case (mode)
      SH_SLL:  result = value << amount;
      SH_SRL:  result = value >> amount;
      SH_SRA:  result = $signed(value) >>> amount;
      default: result = value;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Request/response controller around the alu: decodes R-type funct, runs ALU ops in
// one cycle, shifts iteratively SHIFT_STEP bits per cycle, and holds the response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic [4:0]  req_shamt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_cout,
  output logic        rsp_overflow,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AMT_W = $clog2(SHIFT_STEP + 1);

  state_e           state;
  logic [31:0]      a_q;
  logic [31:0]      b_q;  // rt operand, doubles as the shifter working register
  logic [3:0]       ctrl_q;
  shift_mode_e      mode_q;
  logic             ovf_en_q;
  logic [4:0]       count_q;

  decode_t          dec;
  logic [AMT_W-1:0] step_amt;
  logic [4:0]       count_next;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             alu_cout;
  logic             alu_ovf;
  logic [31:0]      shift_result;

  assign dec        = decode_funct(req_funct);
  assign step_amt   = (count_q < 5'(SHIFT_STEP)) ? count_q[AMT_W-1:0] : AMT_W'(SHIFT_STEP);
  assign count_next = count_q - 5'(step_amt);

  alu u_alu (
    .rst_n       (rst_n),
    .alu_control (ctrl_q),
    .a           (a_q),
    .b           (b_q),
    .result      (alu_result),
    .zero        (alu_zero),
    .cout        (alu_cout),
    .overflow    (alu_ovf)
  );

  shift_step #(.SHIFT_STEP(SHIFT_STEP)) u_shift_step (
    .value  (b_q),
    .mode   (mode_q),
    .amount (step_amt),
    .result (shift_result)
  );

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= ALU_AND;
      mode_q       <= SH_SLL;
      ovf_en_q     <= 1'b0;
      count_q      <= '0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid) begin
            a_q       <= req_src1;
            b_q       <= req_src2;
            ctrl_q    <= dec.ctrl;
            mode_q    <= dec.mode;
            ovf_en_q  <= dec.ovf_en;
            count_q   <= req_shamt;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            case (dec.cls)
              OP_ALU:   state <= ALU;
              OP_SHIFT: state <= SHIFT;
              default: begin
                state        <= RESP;
                rsp_valid    <= 1'b1;
                rsp_result   <= '0;
                rsp_zero     <= 1'b0;
                rsp_cout     <= 1'b0;
                rsp_overflow <= 1'b0;
                rsp_err      <= 1'b1;
              end
            endcase
          end
        end
        ALU: begin
          state        <= RESP;
          rsp_valid    <= 1'b1;
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_cout     <= alu_cout;
          rsp_overflow <= alu_ovf & ovf_en_q;
          rsp_err      <= 1'b0;
        end
        SHIFT: begin
          b_q     <= shift_result;
          count_q <= count_next;
          // shamt=0 also lands here on the first pass, with a zero-bit step
          if (count_next == '0) begin
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_result   <= shift_result;
            rsp_zero     <= (shift_result == '0);
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: one instance with SHIFT_STEP=1, one with SHIFT_STEP=4.
module tb_alu_issue_ctrl;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [5:0]  req_funct;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [4:0]  req_shamt;
  logic        rsp_ready;
  logic        sel4;

  logic        v1, v4;
  logic        rdy1, rdy4, val1, val4, z1, z4, c1, c4, o1, o4, e1, e4, b1, b4;
  logic [31:0] res1, res4;

  logic        m_req_ready, m_rsp_valid, m_zero, m_cout, m_ovf, m_err, m_busy;
  logic [31:0] m_result;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  assign v1 = req_valid & ~sel4;
  assign v4 = req_valid & sel4;

  assign m_req_ready = sel4 ? rdy4 : rdy1;
  assign m_rsp_valid = sel4 ? val4 : val1;
  assign m_result    = sel4 ? res4 : res1;
  assign m_zero      = sel4 ? z4 : z1;
  assign m_cout      = sel4 ? c4 : c1;
  assign m_ovf       = sel4 ? o4 : o1;
  assign m_err       = sel4 ? e4 : e1;
  assign m_busy      = sel4 ? b4 : b1;

  alu_issue_ctrl #(.SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
    .req_funct(req_funct), .req_src1(req_src1), .req_src2(req_src2), .req_shamt(req_shamt),
    .rsp_valid(val1), .rsp_ready(rsp_ready), .rsp_result(res1), .rsp_zero(z1),
    .rsp_cout(c1), .rsp_overflow(o1), .rsp_err(e1), .busy(b1)
  );

  alu_issue_ctrl #(.SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(rdy4),
    .req_funct(req_funct), .req_src1(req_src1), .req_src2(req_src2), .req_shamt(req_shamt),
    .rsp_valid(val4), .rsp_ready(rsp_ready), .rsp_result(res4), .rsp_zero(z4),
    .rsp_cout(c4), .rsp_overflow(o4), .rsp_err(e4), .busy(b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic c,
                              input logic o, input logic e, input int lat);
    exp_t x;
    x.result = r; x.zero = z; x.cout = c; x.ovf = o; x.err = e; x.lat = lat;
    return x;
  endfunction

  // Independent reference for the expected response of one request.
  function automatic exp_t model(input logic [5:0] f, input logic [31:0] s1,
                                 input logic [31:0] s2, input logic [4:0] sh, input int step);
    exp_t x;
    logic [32:0] t;
    x = mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    case (f)
      6'h20, 6'h21: begin
        t = {1'b0, s1} + {1'b0, s2};
        x.result = t[31:0]; x.cout = t[32];
        x.ovf = (f == 6'h20) && (s1[31] == s2[31]) && (t[31] != s1[31]);
      end
      6'h22, 6'h23: begin
        t = {1'b0, s1} + {1'b0, ~s2} + 33'd1;
        x.result = t[31:0]; x.cout = t[32];
        x.ovf = (f == 6'h22) && (s1[31] != s2[31]) && (t[31] != s1[31]);
      end
      6'h24: x.result = s1 & s2;
      6'h25: x.result = s1 | s2;
      6'h27: x.result = ~(s1 | s2);
      6'h2A: x.result = ($signed(s1) < $signed(s2)) ? 32'd1 : 32'd0;
      6'h00, 6'h02, 6'h03: begin
        if (f == 6'h00)      x.result = s2 << sh;
        else if (f == 6'h02) x.result = s2 >> sh;
        else                 x.result = $signed(s2) >>> sh;
        x.lat = 1 + ((sh == 0) ? 1 : (int'(sh) + step - 1) / step);
      end
      default: begin x.err = 1'b1; x.lat = 1; end
    endcase
    x.zero = !x.err && (x.result == 32'd0);
    return x;
  endfunction

  // Drive one request, then wait for its response and compare against the scoreboard.
  // During 'hold' cycles the response is back-pressured while other requests are offered.
  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [4:0] sh, input exp_t e, input int hold);
    exp_t x;
    int   n;
    int   lat;
    sb.push_back(e);
    @(negedge clk);
    req_funct = f; req_src1 = s1; req_src2 = s2; req_shamt = sh; req_valid = 1'b1;
    n = 0;
    while (!m_req_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_accept"}, 32'(n < 50), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!m_rsp_valid && lat < 100);
    x = sb.pop_front();
    check({tag, "_lat"},    32'(lat),    32'(x.lat));
    check({tag, "_result"}, m_result,    x.result);
    check({tag, "_zero"},   32'(m_zero), 32'(x.zero));
    check({tag, "_cout"},   32'(m_cout), 32'(x.cout));
    check({tag, "_ovf"},    32'(m_ovf),  32'(x.ovf));
    check({tag, "_err"},    32'(m_err),  32'(x.err));
    for (int i = 0; i < hold; i++) begin
      req_valid = i[0];
      req_funct = 6'h25; req_src1 = 32'h1234_5678; req_src2 = 32'h0F0F_0F0F;
      @(negedge clk);
      check({tag, "_bp_valid"},  32'(m_rsp_valid),  32'd1);
      check({tag, "_bp_result"}, m_result,          x.result);
      check({tag, "_bp_err"},    32'(m_err),        32'(x.err));
      check({tag, "_bp_ready"},  32'(m_req_ready),  32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(m_req_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(m_rsp_valid), 32'd0);
  endtask

  localparam logic [5:0] FLIST [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                        6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};

  initial begin
    logic [5:0]  f;
    logic [31:0] s1, s2;
    logic [4:0]  sh;

    rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; sel4 = 1'b0;
    req_funct = '0; req_src1 = '0; req_src2 = '0; req_shamt = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(m_req_ready), 32'd0);
    check("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    check("rst_busy",      32'(m_busy),      32'd0);
    check("rst_result",    m_result,         32'd0);
    check("rst_flags",     {28'd0, m_zero, m_cout, m_ovf, m_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(m_req_ready), 32'd1);

    do_op("add_ovf",  6'h20, 32'h7FFF_FFFF, 32'h1, 5'd0, mk(32'h8000_0000, 0, 0, 1, 0, 2), 0);
    do_op("addu",     6'h21, 32'h7FFF_FFFF, 32'h1, 5'd0, mk(32'h8000_0000, 0, 0, 0, 0, 2), 0);
    do_op("subu_eq",  6'h23, 32'd5, 32'd5, 5'd0, mk(32'd0, 1, 1, 0, 0, 2), 0);
    do_op("slt_neg",  6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0, mk(32'd1, 0, 0, 0, 0, 2), 0);
    do_op("slt_pos",  6'h2A, 32'd1, 32'hFFFF_FFFF, 5'd0, mk(32'd0, 1, 0, 0, 0, 2), 0);
    do_op("sra4",     6'h03, 32'd0, 32'h8000_0000, 5'd4, mk(32'hF800_0000, 0, 0, 0, 0, 5), 0);
    do_op("srl4",     6'h02, 32'd0, 32'h8000_0000, 5'd4, mk(32'h0800_0000, 0, 0, 0, 0, 5), 0);
    do_op("sll0",     6'h00, 32'd0, 32'h8000_0000, 5'd0, mk(32'h8000_0000, 0, 0, 0, 0, 2), 0);
    do_op("err18",    6'h18, 32'hDEAD_BEEF, 32'h1, 5'd3, mk(32'd0, 0, 0, 0, 1, 1), 0);
    do_op("bp_and",   6'h24, 32'hF0F0_00FF, 32'hFF00_0F0F, 5'd0,
          mk(32'hF000_000F, 0, 0, 0, 0, 2), 10);

    for (int i = 0; i < 10; i++) begin
      f  = FLIST[$urandom_range(0, 10)];
      s1 = $urandom; s2 = $urandom; sh = 5'($urandom_range(0, 31));
      do_op("rand", f, s1, s2, sh, model(f, s1, s2, sh, 1), 0);
    end

    // Reset in the middle of a long shift aborts it with no response.
    @(negedge clk);
    req_funct = 6'h00; req_src2 = 32'h1; req_shamt = 5'd20; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(m_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_rsp_valid), 32'd0);
    check("mid_rst_busy",  32'(m_busy),      32'd0);
    check("mid_rst_ready", 32'(m_req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(m_req_ready), 32'd1);
    check("post_rst_valid", 32'(m_rsp_valid), 32'd0);
    do_op("post_rst_add", 6'h20, 32'd100, 32'd23, 5'd0, mk(32'd123, 0, 0, 0, 0, 2), 0);

    sel4 = 1'b1;
    do_op("s4_sra31", 6'h03, 32'd0, 32'h8000_0000, 5'd31, mk(32'hFFFF_FFFF, 0, 0, 0, 0, 9), 0);
    for (int i = 0; i < 4; i++) begin
      f  = FLIST[$urandom_range(8, 10)];
      s2 = $urandom; sh = 5'($urandom_range(0, 31));
      do_op("s4_rand", f, 32'd0, s2, sh, model(f, 32'd0, s2, sh, 4), 0);
    end
    sel4 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

- Request-side controller for the `alu` datapath block.
- Accepts one MIPS R-type operation per valid/ready handshake and decodes `funct` into the 4-bit `ALU_control` encoding.
- Runs the operation through an `alu` instance and returns the registered result and flags on a response handshake.
- Implements shifts that `alu` lacks with an iterative multi-cycle shifter. Sits between instruction decode and the writeback/result consumer.

## Interface

Parameters:
- `SHIFT_STEP`, default 1: bits shifted per cycle. Legal values are 1, 2, 4, 8.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept a request.
- `req_funct`  in  6: R-type funct code.
- `req_src1`  in  32: rs operand.
- `req_src2`  in  32: rt operand. This is also the shift operand.
- `req_shamt`  in  5: shift amount.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer takes the response.
- `rsp_result`  out  32: operation result.
- `rsp_zero`, `rsp_cout`, `rsp_overflow`  out  1 each: result flags.
- `rsp_err`  out  1: unsupported funct.
- `busy`  out  1: high in any state other than IDLE.

## Operation

Funct decode to `ALU_control`:
- add 0x20 → 0010
- addu 0x21 → 0010
- sub 0x22 → 0110
- subu 0x23 → 0110
- and 0x24 → 0000
- or 0x25 → 0001
- nor 0x27 → 1100
- slt 0x2A → 0111

Shifts (sll 0x00, srl 0x02, sra 0x03) use the shifter. Any other funct is an error.

State machine:
- **IDLE**: `req_ready`=1. On `req_valid`, register operands and the decoded control, then move to:
  - ALU for ALU ops;
  - SHIFT for shifts, with remaining count = shamt;
  - RESP for errors.
- **ALU**: one cycle with the registered inputs driving `alu`. Capture result, zero, cout and overflow, then go to RESP.
- **SHIFT**: each cycle, shift the working register by min(`SHIFT_STEP`, remaining) and decrement the count.
  - When the count becomes 0, go to RESP.
  - Entering with shamt=0 spends exactly one cycle and leaves the value unchanged.
  - sll and srl zero-fill. sra fills with bit 31.
- **RESP**: `rsp_valid`=1 and all `rsp_*` outputs held stable. On `rsp_ready`, go to IDLE.

Flag rules:
- zero = (result == 0) for every non-error op.
- cout comes from `alu`, which is nonzero only for add/sub-class controls. cout is 0 for shifts.
- overflow comes from `alu` for add and sub. It is forced to 0 for addu, subu, logical ops, slt and shifts.
- Error response: result 0, zero 0, cout 0, overflow 0, err 1.

Other rules:
- The `alu` instance's `rst_n` is tied to `rst_n`.
- `req_valid` outside IDLE is ignored and not acknowledged.
- `rsp_ready` while `rsp_valid`=0 is ignored.

## Timing

- Reset (asynchronous assert, synchronous deassert at the next edge):
  - state goes to IDLE;
  - `req_ready`=0 while `rst_n` is low, then 1;
  - `rsp_valid`, `rsp_result`, all flags, `rsp_err` and `busy` = 0.
- Latency, counting the accept edge as cycle 0:
  - ALU ops: `rsp_valid` at cycle 2.
  - Shifts: `rsp_valid` at cycle 1 + max(1, ceil(shamt/`SHIFT_STEP`)).
  - Errors: `rsp_valid` at cycle 1.
- No overlap between requests. After the response handshake at cycle N, `req_ready` is 1 at cycle N+1. Throughput is at best one op per 3 cycles for ALU ops.
- Responses are held indefinitely under backpressure. `rsp_ready` may be held high continuously.
- Reset mid-operation aborts the operation; no response is produced.

## Structure

- Shared package `alu_pkg` contains:
  - funct localparams;
  - `ALU_control` encodings (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`);
  - the FSM state encoding (IDLE, ALU, SHIFT, RESP).
- Sub-modules:
  - instantiates the existing `alu` unchanged;
  - one new sub-module, `shift_step`: combinational, shifts a 32-bit value by 0..`SHIFT_STEP` bits under a 2-bit mode (sll, srl, sra).

## Test plan

- add 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, zero 0, `rsp_valid` at cycle 2. addu with the same operands → overflow 0.
- subu 5 − 5 → result 0, zero 1, overflow 0, cout 1.
- slt src1 = 0xFFFFFFFF, src2 = 1 → result 1. slt src1 = 1, src2 = 0xFFFFFFFF → result 0.
- `SHIFT_STEP`=1, src2 = 0x80000000, shamt 4:
  - sra → 0xF8000000, `rsp_valid` at cycle 5;
  - srl → 0x08000000;
  - shamt 0 → 0x80000000 at cycle 2.
  - With `SHIFT_STEP`=4 and shamt 31, `rsp_valid` is at cycle 9.
- funct 0x18 → err 1, result 0, `rsp_valid` at cycle 1.
- Backpressure: hold `rsp_ready`=0 for 10 cycles and pulse `req_valid` with a different request → response stable, `req_ready`=0, no second accept.
- Reset mid-operation: assert `rst_n`=0 during SHIFT → `rsp_valid`=0 and `busy`=0 immediately. After release, `req_ready`=1 and the next add completes normally.
